// File: rtl/scan_memory_bank_io.sv
// scan_memory_bank_io: a bank of byte cells plus memory-mapped GPIO registers.
// Every storage element except the input synchroniser stage is on one serial
// scan chain. Cell 0 bit 0 is the chain head, and the last register's MSB is
// scan_out.
// Optional feature macro: SCAN_MEM_BANK_EDGE_CAPTURE_EN adds the rising-edge
// capture register (write-1-to-clear) as the last register on the chain.
module scan_memory_bank_io #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_SIZE   = 2**ADDR_WIDTH - 3,
  parameter int OUT_ADDR   = MEM_SIZE,
  parameter int IN_ADDR    = MEM_SIZE + 1,
  parameter int EDGE_ADDR  = MEM_SIZE + 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  write_enable,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  scan_enable,
  input  logic                  scan_in,
  output logic                  scan_out,
  input  logic [DATA_WIDTH-1:0] in_pins,
  output logic [DATA_WIDTH-1:0] out_pins
);

  // The cells and the three GPIO registers must all fit in the address space.
  if ((MEM_SIZE + 3) > (2**ADDR_WIDTH)) begin : g_bad_size
    $error("scan_memory_bank_io: MEM_SIZE+3 exceeds 2**ADDR_WIDTH");
  end
  if ((OUT_ADDR >= 2**ADDR_WIDTH) || (IN_ADDR >= 2**ADDR_WIDTH) ||
      (EDGE_ADDR >= 2**ADDR_WIDTH)) begin : g_bad_addr
    $error("scan_memory_bank_io: register address outside the address space");
  end

`ifdef SCAN_MEM_BANK_EDGE_CAPTURE_EN
  localparam int NUM_REGS = MEM_SIZE + 3;
  localparam logic [ADDR_WIDTH-1:0] EDGE_A = EDGE_ADDR[ADDR_WIDTH-1:0];
`else
  localparam int NUM_REGS = MEM_SIZE + 2;
`endif
  localparam int CHAIN_LEN = DATA_WIDTH * NUM_REGS;
  localparam logic [ADDR_WIDTH-1:0] OUT_A = OUT_ADDR[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] IN_A  = IN_ADDR[ADDR_WIDTH-1:0];

  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];
  logic [DATA_WIDTH-1:0] mem_d [MEM_SIZE];
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [DATA_WIDTH-1:0] s1_q;
  logic [DATA_WIDTH-1:0] in_q, in_d;
`ifdef SCAN_MEM_BANK_EDGE_CAPTURE_EN
  logic [DATA_WIDTH-1:0] edge_q, edge_d;
  logic [DATA_WIDTH-1:0] clr_s;
`endif
  logic [CHAIN_LEN-1:0]  chain_s;
  logic [CHAIN_LEN-1:0]  shift_s;
  logic [DATA_WIDTH-1:0] rd_s;
  logic                  wr_s;

  // A functional write only happens outside scan mode.
  assign wr_s = write_enable & ~scan_enable;

  // Flatten all chained registers into one vector, cell 0 bit 0 at the LSB.
  always_comb begin
    chain_s = '0;
    for (int i = 0; i < MEM_SIZE; i++) begin
      chain_s[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
    end
    chain_s[MEM_SIZE*DATA_WIDTH +: DATA_WIDTH]     = out_q;
    chain_s[(MEM_SIZE+1)*DATA_WIDTH +: DATA_WIDTH] = in_q;
`ifdef SCAN_MEM_BANK_EDGE_CAPTURE_EN
    chain_s[(MEM_SIZE+2)*DATA_WIDTH +: DATA_WIDTH] = edge_q;
`endif
    shift_s = {chain_s[CHAIN_LEN-2:0], scan_in};
  end

  assign scan_out = chain_s[CHAIN_LEN-1];
  assign out_pins = out_q;

`ifdef SCAN_MEM_BANK_EDGE_CAPTURE_EN
  // Write-1-to-clear mask for the edge register.
  always_comb begin
    clr_s = (wr_s && (address == EDGE_A)) ? data_in : {DATA_WIDTH{1'b0}};
  end
`endif

  // Next-state: shift the whole chain in scan mode, otherwise apply writes and the input pipeline.
  always_comb begin
    mem_d = mem_q;
    out_d = out_q;
    in_d  = in_q;
`ifdef SCAN_MEM_BANK_EDGE_CAPTURE_EN
    edge_d = edge_q;
`endif
    if (scan_enable) begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        mem_d[i] = shift_s[i*DATA_WIDTH +: DATA_WIDTH];
      end
      out_d = shift_s[MEM_SIZE*DATA_WIDTH +: DATA_WIDTH];
      in_d  = shift_s[(MEM_SIZE+1)*DATA_WIDTH +: DATA_WIDTH];
`ifdef SCAN_MEM_BANK_EDGE_CAPTURE_EN
      edge_d = shift_s[(MEM_SIZE+2)*DATA_WIDTH +: DATA_WIDTH];
`endif
    end else begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        mem_d[i] = (wr_s && (address == ADDR_WIDTH'(i))) ? data_in : mem_q[i];
      end
      out_d = (wr_s && (address == OUT_A)) ? data_in : out_q;
      in_d  = s1_q;
`ifdef SCAN_MEM_BANK_EDGE_CAPTURE_EN
      // A rise seen on the same edge as a clear of that bit wins.
      edge_d = (edge_q & ~clr_s) | (s1_q & ~in_q);
`endif
    end
  end

  // Combinational read mux; unmapped addresses read zero.
  always_comb begin
    rd_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < MEM_SIZE; i++) begin
      rd_s = rd_s | ({DATA_WIDTH{address == ADDR_WIDTH'(i)}} & mem_q[i]);
    end
    rd_s = rd_s | ({DATA_WIDTH{address == OUT_A}} & out_q);
    rd_s = rd_s | ({DATA_WIDTH{address == IN_A}} & in_q);
`ifdef SCAN_MEM_BANK_EDGE_CAPTURE_EN
    rd_s = rd_s | ({DATA_WIDTH{address == EDGE_A}} & edge_q);
`endif
    data_out = rd_s;
  end

  // State registers, cleared asynchronously; the synchroniser samples in every mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_SIZE; i++) begin
        mem_q[i] <= {DATA_WIDTH{1'b0}};
      end
      out_q <= {DATA_WIDTH{1'b0}};
      s1_q  <= {DATA_WIDTH{1'b0}};
      in_q  <= {DATA_WIDTH{1'b0}};
`ifdef SCAN_MEM_BANK_EDGE_CAPTURE_EN
      edge_q <= {DATA_WIDTH{1'b0}};
`endif
    end else begin
      mem_q <= mem_d;
      out_q <= out_d;
      s1_q  <= in_pins;
      in_q  <= in_d;
`ifdef SCAN_MEM_BANK_EDGE_CAPTURE_EN
      edge_q <= edge_d;
`endif
    end
  end

endmodule

// File: tb/tb_scan_memory_bank_io.sv
// Testbench for scan_memory_bank_io with default parameters. The model keeps
// every register as a byte and treats the chain as a carry rippling through
// them. Honours SCAN_MEM_BANK_EDGE_CAPTURE_EN the same way as the design.
module tb_scan_memory_bank_io;

  localparam int MS = 29;
`ifdef SCAN_MEM_BANK_EDGE_CAPTURE_EN
  localparam int EN = 1;
`else
  localparam int EN = 0;
`endif
  localparam int NREG = MS + 2 + EN;
  localparam int L    = 8 * NREG;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] address;
  logic [7:0] data_in;
  logic       write_enable;
  logic [7:0] data_out;
  logic       scan_enable;
  logic       scan_in;
  logic       scan_out;
  logic [7:0] in_pins;
  logic [7:0] out_pins;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: m_reg[0..MS-1] cells, [MS] OUT, [MS+1] IN, [MS+2] EDGE.
  logic [7:0] m_reg [MS+3];
  logic [7:0] m_s1;

  scan_memory_bank_io dut (
    .clk(clk), .rst(rst), .address(address), .data_in(data_in),
    .write_enable(write_enable), .data_out(data_out),
    .scan_enable(scan_enable), .scan_in(scan_in), .scan_out(scan_out),
    .in_pins(in_pins), .out_pins(out_pins)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < MS + 3; r++) m_reg[r] = 8'h00;
    m_s1 = 8'h00;
  endtask

  function automatic logic [7:0] model_read(input logic [4:0] a);
    if (a < 5'(MS))               return m_reg[a];
    else if (a == 5'(MS))         return m_reg[MS];
    else if (a == 5'(MS + 1))     return m_reg[MS+1];
    else if (a == 5'(MS + 2) && EN == 1) return m_reg[MS+2];
    else                          return 8'h00;
  endfunction

  // Apply the spec's rules for one clock edge to the model.
  task automatic model_tick();
    logic       carry, nc;
    logic [7:0] clr;
    if (rst) begin
      model_clear();
      return;
    end
    if (scan_enable) begin
      carry = scan_in;
      for (int r = 0; r < NREG; r++) begin
        nc       = m_reg[r][7];
        m_reg[r] = {m_reg[r][6:0], carry};
        carry    = nc;
      end
    end else begin
      if (write_enable && address < 5'(MS)) m_reg[address] = data_in;
      if (write_enable && address == 5'(MS)) m_reg[MS] = data_in;
      if (EN == 1) begin
        clr = (write_enable && address == 5'(MS + 2)) ? data_in : 8'h00;
        m_reg[MS+2] = (m_reg[MS+2] & ~clr) | (m_s1 & ~m_reg[MS+1]);
      end
      m_reg[MS+1] = m_s1;
    end
    m_s1 = in_pins;
  endtask

  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic read_check(input string name, input logic [4:0] a, input logic [7:0] exp);
    address = a;
    #1;
    check(name, 32'(data_out), 32'(exp));
  endtask

  task automatic write(input logic [4:0] a, input logic [7:0] d);
    address = a; data_in = d; write_enable = 1'b1;
    step();
    write_enable = 1'b0;
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_data_out", 32'(data_out), 32'(model_read(address)));
      check("cyc_out_pins", 32'(out_pins), 32'(m_reg[MS]));
      check("cyc_scan_out", 32'(scan_out), 32'(m_reg[NREG-1][7]));
    end
  end

  logic [255:0] pat, got;
  int           n;

  initial begin
    rst = 1'b1; address = 5'd0; data_in = 8'h00; write_enable = 1'b0;
    scan_enable = 1'b0; scan_in = 1'b0; in_pins = 8'h00;
    model_clear();
    step();
    step();
    // Reset readback of the full address space.
    for (int a = 0; a < 32; a++) read_check("reset_read", 5'(a), 8'h00);
    check("reset_out_pins", 32'(out_pins), 32'h0);
    check("reset_scan_out", 32'(scan_out), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    step();

    // Memory and OUT writes; IN is read-only.
    write(5'd3, 8'hA5);
    read_check("mem3", 5'd3, 8'hA5);
    write(5'd29, 8'h3C);
    check("out_pins_3c", 32'(out_pins), 32'h3C);
    read_check("out_read", 5'd29, 8'h3C);
    write(5'd30, 8'hFF);
    read_check("in_ignore_wr", 5'd30, 8'h00);

    // Input synchroniser: two edges of latency.
    in_pins = 8'h81;
    step();
    read_check("in_lat1", 5'd30, 8'h00);
    step();
    read_check("in_lat2", 5'd30, 8'h81);
    read_check("edge_rise", 5'd31, (EN == 1) ? 8'h81 : 8'h00);

    if (EN == 1) begin
      write(5'd31, 8'h01);
      read_check("edge_w1c", 5'd31, 8'h80);
      in_pins = 8'h80;
      step();
      step();
      in_pins = 8'h81;
      step();
      write(5'd31, 8'h01);
      read_check("edge_set_wins", 5'd31, 8'h81);
    end else begin
      write(5'd31, 8'hFF);
      read_check("edge_absent", 5'd31, 8'h00);
    end

    // Chain length: flush with zeros, inject a single 1, count until it emerges.
    scan_enable = 1'b1;
    scan_in = 1'b0;
    for (int i = 0; i < L; i++) step();
    scan_in = 1'b1;
    step();
    scan_in = 1'b0;
    n = 1;
    while (scan_out !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    check("chain_len", 32'(n), (EN == 1) ? 32'd256 : 32'd248);
    for (int i = 0; i < L; i++) step();

    // Scan load: cell 0 = 0x5A, OUT = 0xF0, others arbitrary.
    pat = '0;
    for (int r = 0; r < NREG; r++) pat[r*8 +: 8] = 8'(r * 37 + 11);
    pat[7:0] = 8'h5A;
    pat[MS*8 +: 8] = 8'hF0;
    for (int i = 0; i < L; i++) begin
      scan_in = pat[L-1-i];
      step();
    end
    scan_in = 1'b0;
    read_check("scan_cell0", 5'd0, 8'h5A);
    check("scan_out_pins", 32'(out_pins), 32'hF0);

    // Scan unload reproduces the loaded pattern.
    got = '0;
    for (int i = 0; i < L; i++) begin
      got[L-1-i] = scan_out;
      step();
    end
    n_checks++;
    if (got !== pat) begin
      n_fail++;
      $display("FAIL scan_unload: got %h expected %h", got, pat);
    end

    // Back to functional mode: IN reloads from the synchroniser.
    scan_enable = 1'b0;
    in_pins = 8'h55;
    step();
    step();
    read_check("in_after_scan", 5'd30, 8'h55);

    // Asynchronous reset mid-operation clears at once.
    write(5'd29, 8'h77);
    check("out_pins_77", 32'(out_pins), 32'h77);
    #2;
    chk_en = 1'b0;
    rst = 1'b1;
    model_clear();
    address = 5'd29;
    #1;
    check("async_rst_out_pins", 32'(out_pins), 32'h0);
    check("async_rst_read", 32'(data_out), 32'h0);
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    step();
    read_check("post_rst_read", 5'd29, 8'h00);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scan_memory_bank_io.md
# scan_memory_bank_io

Parametrised scan-chain memory bank with memory-mapped general-purpose I/O, the successor to the fixed 31-byte, LED/button bank in the processor's memory subsystem. It provides MEM_SIZE read/write byte cells, a full-width output port register, a synchronised full-width input port register and an optional rising-edge capture register. Every storage element sits on one serial scan chain used for program load and state readout.

## Interface
- ADDR_WIDTH, 5: address bus width.
- DATA_WIDTH, 8: word width; also the width of the in/out pin ports.
- MEM_SIZE, 2**ADDR_WIDTH-3: number of general memory cells; MEM_SIZE+3 <= 2**ADDR_WIDTH is required, with a elaboration error otherwise.
- OUT_ADDR, MEM_SIZE: output register address. IN_ADDR, MEM_SIZE+1: input register address. EDGE_ADDR, MEM_SIZE+2: edge-capture register address.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- address  in  ADDR_WIDTH  read/write address.
- data_in  in  DATA_WIDTH  write data.
- write_enable  in  1  write strobe.
- data_out  out  DATA_WIDTH  combinational read data.
- scan_enable  in  1  shift mode.
- scan_in  in  1  serial chain input.
- scan_out  out  1  serial chain output.
- in_pins  in  DATA_WIDTH  asynchronous external inputs.
- out_pins  out  DATA_WIDTH  external outputs, driven directly from the OUT register.

## Operation
- Reset (async, rst=1): all cells, OUT, the synchroniser stage s1, IN and EDGE are cleared to 0. Outputs: out_pins=0, scan_out=0, data_out=0.
- Functional mode (scan_enable=0):
  - write_enable=1 with address<MEM_SIZE: writes the cell.
  - Write at OUT_ADDR: loads OUT with all DATA_WIDTH bits.
  - Writes to IN_ADDR are ignored.
  - Write at EDGE_ADDR is write-1-to-clear: the EDGE bits where data_in=1 are cleared.
- Read: data_out is selected combinationally from address: cell, OUT, IN or EDGE.
- Input path: in_pins -> s1 -> IN, one flop per clock. s1 samples every cycle in both modes. IN loads s1 only when scan_enable=0.
- Edge capture: EDGE[i] is set when s1[i]=1, IN[i]=0 and scan_enable=0. On the same edge for the same bit, set dominates clear.
- Scan mode (scan_enable=1):
  - Every chained register shifts one bit per clock toward its MSB: scan_in -> bit 0 of cell 0.
  - The MSB of each register feeds bit 0 of the next register.
  - Chain order: cell 0 .. cell MEM_SIZE-1, OUT, IN, EDGE (EDGE only when compiled in). scan_out is the MSB of the last register.
  - write_enable is ignored. Edge detection is suppressed. s1 is not on the chain.
- Chain length: DATA_WIDTH*(MEM_SIZE+2) bits, plus DATA_WIDTH when EDGE is compiled in. Defaults: 248 without EDGE, 256 with EDGE.

## Timing
- Write: data is visible on data_out immediately after the clk edge where write_enable=1.
- out_pins update on the same edge as the OUT write.
- Input latency: an in_pins change stable before edge k is in s1 after edge k. It is readable at IN_ADDR, and the matching EDGE bit is set, after edge k+1.
- Scan: one bit per cycle. After N shift cycles, the first bit shifted in sits N-1 positions down the chain. The chain bit at position L-1 appears on scan_out combinationally.
- Toggling scan_enable mid-operation takes effect at the next edge and no partial write occurs. On return to functional mode, IN reloads from s1 on the first edge.
- Reset asserted mid-scan or mid-write clears everything immediately. Release is synchronous to the next clk edge.

## Configuration
- SCAN_MEM_BANK_EDGE_CAPTURE_EN:
  - Defined: the EDGE register exists, is readable and write-1-to-clear at EDGE_ADDR, and is the last register on the scan chain.
  - Undefined: there is no EDGE register. EDGE_ADDR reads 0, writes there are ignored, and the chain ends at IN.

## Test plan
- Reset and readback: assert rst, then read all 32 addresses -> every read is 0x00, out_pins=0x00.
- Memory/OUT: write 0xA5 to addr 3 and 0x3C to addr 29 (OUT) -> reading addr 3 gives 0xA5, out_pins=0x3C. A write to addr 30 is ignored.
- Input sync: drive in_pins 0x00 -> 0x81 between edges -> addr 30 reads 0x00 after the first edge and 0x81 after the second.
- Edge capture (macro on): after the 0x81 rise, addr 31 reads 0x81. Write 0x01 to addr 31 -> reads 0x80. A simultaneous rise on bit0 with a clear of bit0 -> bit0 stays 1.
- Scan load/unload: shift a 256-bit pattern with cell 0 = 0x5A and OUT = 0xF0 -> addr 0 reads 0x5A, out_pins=0xF0. Shift 256 more cycles -> scan_out reproduces the pattern.
- Macro off: the chain length measures 248. Addr 31 reads 0 after a write of 0xFF.
